// File: rtl/logic_unit_arbiter_if.sv
// Request/response bus for the shared logic unit: two requester channels,
// one response channel and the completed-operation counter.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic [CNT_W-1:0] op_count;

  // Requesters and response consumer
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, op_count
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, op_count
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one AND/NOR logic unit between two requesters.
// Results land in a single-entry registered response buffer; a drain and a
// new accept may happen in the same cycle for full throughput.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_unit_arbiter_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_op;
  logic [WIDTH-1:0] result;

  // Round-robin grant: the buffer must be free (or freeing this cycle);
  // on a tie the requester that did not win last time goes first.
  always_comb begin
    can_accept = (state_q == EMPTY) || bus.rsp_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (can_accept) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
    accept = grant0 | grant1;
    drain  = (state_q == FULL) && bus.rsp_ready;
  end

  // Operand mux and logic unit
  always_comb begin
    sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
    sel_b  = grant1 ? bus.req1_b  : bus.req0_b;
    sel_op = grant1 ? bus.req1_op : bus.req0_op;
    result = sel_op ? ~(sel_a | sel_b) : (sel_a & sel_b);
  end

  // Buffer state: accept wins over drain so back-to-back stays FULL
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (bus.rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Datapath next values: load on accept, otherwise hold; count handshakes
  always_comb begin
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    if (accept) begin
      rsp_data_d   = result;
      rsp_id_d     = grant1;
      last_grant_d = grant1;
    end
    if (drain) begin
      op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Response buffer, priority pointer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      op_count_q   <= '0;
    end else begin
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state_q == FULL);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.op_count   = op_count_q;

endmodule
